// File: rtl/mae_char_ctrl.sv
// Drives an external approximate adder with LFSR operand pairs and accumulates
// sum, maximum and count of absolute errors against the exact sum.
module mae_char_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_samples,
    input  logic [WIDTH-1:0]       seed,
    output logic [WIDTH-1:0]       op_a,
    output logic [WIDTH-1:0]       op_b,
    input  logic [WIDTH:0]         approx_sum,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH+CNT_W:0]   err_sum,
    output logic [WIDTH:0]         err_max,
    output logic [CNT_W-1:0]       err_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    // Galois right-shift toggle masks, maximal length for each width.
    function automatic logic [31:0] taps_for(input int w);
        case (w)
            2:  return 32'h00000003;
            3:  return 32'h00000006;
            4:  return 32'h0000000C;
            5:  return 32'h00000014;
            6:  return 32'h00000030;
            7:  return 32'h00000060;
            8:  return 32'h000000B8;
            9:  return 32'h00000110;
            10: return 32'h00000240;
            11: return 32'h00000500;
            12: return 32'h00000829;
            13: return 32'h0000100D;
            14: return 32'h00002015;
            15: return 32'h00006000;
            17: return 32'h00012000;
            18: return 32'h00020400;
            19: return 32'h00040023;
            20: return 32'h00090000;
            21: return 32'h00140000;
            22: return 32'h00300000;
            23: return 32'h00420000;
            24: return 32'h00E10000;
            25: return 32'h01200000;
            26: return 32'h02000023;
            27: return 32'h04000013;
            28: return 32'h09000000;
            29: return 32'h14000000;
            30: return 32'h20000029;
            31: return 32'h48000000;
            32: return 32'h80200003;
            default: return 32'h0000B400;
        endcase
    endfunction

    localparam logic [31:0]      TAPS32  = taps_for(WIDTH);
    localparam logic [WIDTH-1:0] TAPS    = TAPS32[WIDTH-1:0];
    localparam logic [31:0]      DEFA32  = 32'hACE1ACE1;
    localparam logic [31:0]      DEFB32  = 32'h1D871D87;
    localparam logic [31:0]      MIX32   = 32'h5A5A5A5A;
    localparam logic [WIDTH-1:0] DEF_A   = DEFA32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] DEF_B   = DEFB32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIX     = MIX32[WIDTH-1:0];
    localparam int               HALF    = WIDTH / 2;

    state_t              state_q;
    logic [CNT_W-1:0]    rem_q;
    logic [WIDTH-1:0]    op_a_q, op_b_q;
    logic                s1_vld_q;
    logic [WIDTH:0]      s1_exact_q, s1_approx_q;
    logic                busy_q, done_q;
    logic [WIDTH+CNT_W:0] err_sum_q;
    logic [WIDTH:0]      err_max_q;
    logic [CNT_W-1:0]    err_cnt_q;

    logic [WIDTH-1:0]    lfsr_a_d, lfsr_b_d, seed_a, seed_b, seed_mix;
    logic [WIDTH:0]      exact_d, err_d, err_max_d;
    logic [WIDTH+CNT_W:0] err_sum_d;
    logic [CNT_W-1:0]    err_cnt_d;

    always_comb begin
        lfsr_a_d  = {1'b0, op_a_q[WIDTH-1:1]} ^ (op_a_q[0] ? TAPS : '0);
        lfsr_b_d  = {1'b0, op_b_q[WIDTH-1:1]} ^ (op_b_q[0] ? TAPS : '0);
        // Seed B is the half-swapped seed (a byte swap at 16 bits), decorrelated from A.
        seed_mix  = {seed[HALF-1:0], seed[WIDTH-1:HALF]} ^ MIX;
        seed_a    = (seed == '0) ? DEF_A : seed;
        seed_b    = (seed_mix == '0) ? DEF_B : seed_mix;
        exact_d   = {1'b0, op_a_q} + {1'b0, op_b_q};
        err_d     = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                                : (s1_approx_q - s1_exact_q);
        err_sum_d = err_sum_q + {{CNT_W{1'b0}}, err_d};
        err_max_d = (err_d > err_max_q) ? err_d : err_max_q;
        err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, (err_d != '0)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            s1_vld_q    <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_sum_q   <= '0;
            err_max_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            s1_vld_q <= (state_q == RUN);
            if (state_q == RUN) begin
                s1_exact_q  <= exact_d;
                s1_approx_q <= approx_sum;
            end
            if (s1_vld_q) begin
                err_sum_q <= err_sum_d;
                err_max_q <= err_max_d;
                err_cnt_q <= err_cnt_d;
            end

            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        err_sum_q <= '0;
                        err_max_q <= '0;
                        err_cnt_q <= '0;
                        rem_q     <= num_samples;
                        if (num_samples == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            op_a_q  <= seed_a;
                            op_b_q  <= seed_b;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    op_a_q <= lfsr_a_d;
                    op_b_q <= lfsr_b_d;
                    rem_q  <= rem_q - 1'b1;
                    if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1})
                        state_q <= FLUSH;
                end
                FLUSH: begin
                    // Last sample reaches stage 2 on this edge, so metrics and done align.
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_sum = err_sum_q;
    assign err_max = err_max_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mae_char_ctrl.sv
// Bench for mae_char_ctrl: stub adders, a sample-by-sample reference model,
// table vectors, hand-written corner sequences and randomized runs.
module tb_mae_char_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_samples;
    logic [15:0] seed;
    logic [15:0] op_a, op_b;
    logic [16:0] approx_sum;
    logic        busy, done;
    logic [32:0] err_sum;
    logic [16:0] err_max;
    logic [15:0] err_cnt;

    int mode = 0;
    int checks = 0;
    int failures = 0;

    mae_char_ctrl #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .seed(seed), .op_a(op_a), .op_b(op_b), .approx_sum(approx_sum),
        .busy(busy), .done(done), .err_sum(err_sum), .err_max(err_max),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // mode 0: exact, 1: exact+3, k>=2: ripple adder with k low cells approximate
    function automatic logic [16:0] adder(input logic [15:0] a, input logic [15:0] b, input int md);
        logic       c;
        logic [16:0] s;
        if (md == 0) return {1'b0, a} + {1'b0, b};
        if (md == 1) return {1'b0, a} + {1'b0, b} + 17'd3;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < md) begin
                s[i] = 1'b0;
                c    = ~c;
            end else begin
                s[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
        end
        s[16] = c;
        return s;
    endfunction

    always_comb approx_sum = adder(op_a, op_b, mode);

    function automatic logic [15:0] step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic init_ab(input logic [15:0] sd, output logic [15:0] a, output logic [15:0] b);
        logic [15:0] t;
        a = (sd == 16'h0) ? 16'hACE1 : sd;
        t = {sd[7:0], sd[15:8]} ^ 16'h5A5A;
        b = (t == 16'h0) ? 16'h1D87 : t;
    endtask

    task automatic model(input int md, input logic [15:0] sd, input int n,
                         output longint s, output longint mx, output longint c);
        logic [15:0] a, b;
        longint ex, ap, e;
        init_ab(sd, a, b);
        s = 0; mx = 0; c = 0;
        for (int i = 0; i < n; i++) begin
            ex = longint'(a) + longint'(b);
            ap = longint'(adder(a, b, md));
            e  = (ex > ap) ? ex - ap : ap - ex;
            s += e;
            if (e > mx) mx = e;
            if (e != 0) c++;
            a = step(a);
            b = step(b);
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " op_a"}, op_a, 0);
        chk({tag, " op_b"}, op_b, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " err_sum"}, err_sum, 0);
        chk({tag, " err_max"}, err_max, 0);
        chk({tag, " err_cnt"}, err_cnt, 0);
    endtask

    // One run; glitch>0 pulses start at that cycle, rst_at>0 resets at that cycle.
    task automatic run(input string tag, input int md, input logic [15:0] sd, input int n,
                       input longint es, input longint emx, input longint ec,
                       input int glitch, input int rst_at);
        logic [15:0] a, b;
        int  cyc;
        bit  op_bad, busy_bad;
        longint hold_sum;
        init_ab(sd, a, b);
        mode = md;
        num_samples = 16'(n);
        seed  = sd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; op_bad = 0; busy_bad = 0;
        while (!done && cyc < n + 10) begin
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                chk_zero({tag, " midrst"});
                @(posedge clk); #1;
                chk({tag, " idle busy"}, busy, 0);
                return;
            end
            if (cyc <= n) begin
                if (op_a !== a || op_b !== b) op_bad = 1;
                a = step(a);
                b = step(b);
            end
            if (busy !== 1'b1) busy_bad = 1;
            if (cyc == glitch) begin
                start = 1'b1; num_samples = 16'd3; seed = 16'h0077;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, " latency"}, cyc, (n == 0) ? 1 : n + 2);
        chk({tag, " op trace ok"}, op_bad, 0);
        chk({tag, " busy during run"}, busy_bad, 0);
        chk({tag, " busy at done"}, busy, 0);
        chk({tag, " err_sum"}, err_sum, es);
        chk({tag, " err_max"}, err_max, emx);
        chk({tag, " err_cnt"}, err_cnt, ec);
        hold_sum = err_sum;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " done held"}, done, 1);
        chk({tag, " sum held"}, err_sum, hold_sum);
    endtask

    typedef struct {
        string       name;
        int          md;
        logic [15:0] sd;
        int          n;
        longint      es, emx, ec;
    } vec_t;

    vec_t vecs[5];

    initial begin
        longint s, mx, c;
        int md, n;
        logic [15:0] sd;

        rst_n = 1'b0; start = 1'b0; num_samples = '0; seed = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs[0] = '{"exact100", 0, 16'h0001, 100, 0, 0, 0};
        vecs[1] = '{"offset50", 1, 16'h1234, 50, 150, 3, 50};
        vecs[2] = '{"zero",     0, 16'h0000, 0, 0, 0, 0};
        vecs[3] = '{"offset1",  1, 16'hBEEF, 1, 3, 3, 1};
        vecs[4] = '{"zero_from_done", 1, 16'h5A5A, 0, 0, 0, 0};
        foreach (vecs[i])
            run(vecs[i].name, vecs[i].md, vecs[i].sd, vecs[i].n,
                vecs[i].es, vecs[i].emx, vecs[i].ec, 0, 0);

        // Spec approximate adder: 9 low cells approximate
        model(9, 16'hC0DE, 1000, s, mx, c);
        run("approx1000", 9, 16'hC0DE, 1000, s, mx, c, 0, 0);
        chk("approx max bound", (err_max <= 17'h005FF), 1);
        chk("approx cnt nonzero", (err_cnt > 0), 1);

        // Seed B zero fallback
        model(9, 16'h5A5A, 12, s, mx, c);
        run("seedb_fallback", 9, 16'h5A5A, 12, s, mx, c, 0, 0);

        // Start ignored mid-run
        model(9, 16'h3C3C, 20, s, mx, c);
        run("start_ignored", 9, 16'h3C3C, 20, s, mx, c, 5, 0);

        // Reset mid-run, then a seed-0 run uses the ACE1 default
        run("reset_mid", 9, 16'h4242, 40, 0, 0, 0, 0, 10);
        model(9, 16'h0000, 40, s, mx, c);
        run("after_reset_seed0", 9, 16'h0000, 40, s, mx, c, 0, 0);

        for (int r = 0; r < 8; r++) begin
            md = int'($urandom_range(0, 12));
            n  = int'($urandom_range(0, 60));
            sd = 16'($urandom);
            model(md, sd, n, s, mx, c);
            run($sformatf("rand%0d", r), md, sd, n, s, mx, c, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
